// File: rtl/uart_rx_deserializer_if.sv
// rtl/uart_rx_deserializer_if.sv - byte delivery handshake between the UART receiver and its consumer
//
// Purpose: carries one received byte from the receiver's holding register to
// the CPU-side UART register block with a valid/ready handshake. A byte moves
// on every clock edge where rx_valid and rx_ready are both high.
//
// Signals:
//   rx_data  [7:0]  received byte, stable while rx_valid is high and not yet taken
//   rx_valid        holding register full (driven by the receiver)
//   rx_ready        consumer accepts rx_data this cycle (driven by the consumer)
//
// Modports:
//   master  receiver side: drives rx_data/rx_valid, observes rx_ready
//   slave   consumer side: observes rx_data/rx_valid, drives rx_ready

interface uart_rx_deserializer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - 8N1 UART receiver with majority-voted sampling and a one-entry holding register
//
// Purpose: receives 8N1 frames on the console line and hands each byte to the
// CPU-side register block through a one-entry valid/ready holding register.
// Framing errors and overruns are reported as registered one-cycle pulses.
//
// Ports:
//   clk            system clock (CLOCK_FREQUENCY Hz)
//   reset          asynchronous, active-high reset
//   uart_rxd       asynchronous serial input, idles high
//   rx_if          master side of the byte handshake (rx_data, rx_valid, rx_ready)
//   framing_error  one-cycle pulse: stop bit sampled low
//   overrun        one-cycle pulse: completed byte dropped, holding register was full
//   busy           high whenever the receiver is not idle

module uart_rx_deserializer #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 1_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   uart_rxd,
  uart_rx_deserializer_if.master rx_if,
  output logic                   framing_error,
  output logic                   overrun,
  output logic                   busy
);

  // Clocks per bit and the start-bit centring delay.
  localparam int DIV   = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  // Below eight clocks per bit the three-sample vote and the start-bit
  // recheck no longer sit safely inside one bit period.
  if (DIV < 8) begin : g_div_too_small
    $error("uart_rx_deserializer: CLOCK_FREQUENCY / BAUD_RATE must be at least 8");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t           state_q;
  logic [1:0]       sync_q;      // [0] first flop, [1] synchronised sample
  logic [2:0]       hist_q;      // last three synchronised samples
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;     // byte being assembled, LSB arrives first
  logic [7:0]       data_q;      // holding register
  logic             valid_q;
  logic             framing_error_q;
  logic             overrun_q;
  logic             busy_q;

  logic sample_d;    // synchronised line sample
  logic line_d;      // majority vote of the history, used for every bit decision

  assign sample_d = sync_q[1];
  assign line_d   = (hist_q[0] & hist_q[1]) |
                    (hist_q[0] & hist_q[2]) |
                    (hist_q[1] & hist_q[2]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      sync_q          <= 2'b11;
      hist_q          <= 3'b111;
      cnt_q           <= '0;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'h00;
      data_q          <= 8'h00;
      valid_q         <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], uart_rxd};
      hist_q <= {hist_q[1:0], sample_d};

      // Error flags are pulses: they only stay high for the cycle after
      // the decision that raised them.
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;

      // Consumer handshake. A byte completing in the same cycle overrides
      // this below, so a simultaneous take-and-refill keeps rx_valid high.
      if (valid_q && rx_if.rx_ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          // Falling edge seen on the raw synchronised sample; the vote is
          // only consulted at the start-bit centre.
          if (!sample_d) begin
            state_q <= ST_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        ST_START: begin
          if (cnt_q == CNT_HALF) begin
            if (line_d) begin
              // Line back high at mid start bit: treat as noise, silently.
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= ST_DATA;
              cnt_q     <= '0;
              bit_idx_q <= 3'd0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {line_d, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (line_d) begin
              // Return to IDLE straight from the stop-bit centre so a start
              // bit that follows with no idle gap is still caught.
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              if (!valid_q || rx_if.rx_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              // Byte discarded; BREAK absorbs a held-low line so it yields
              // exactly one framing error rather than a stream of them.
              framing_error_q <= 1'b1;
              state_q         <= ST_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_BREAK: begin
          if (sample_d) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign framing_error  = framing_error_q;
  assign overrun        = overrun_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - self-checking bench for the 8N1 UART receiver

module tb_uart_rx_deserializer;

  localparam int DIV  = 100;
  localparam int HALF = DIV / 2;

  logic clk = 1'b0;
  logic reset;
  logic uart_rxd;
  logic framing_error;
  logic overrun;
  logic busy;

  uart_rx_deserializer_if rx_if ();

  uart_rx_deserializer #(
    .CLOCK_FREQUENCY(100_000_000),
    .BAUD_RATE      (1_000_000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rxd     (uart_rxd),
    .rx_if        (rx_if),
    .framing_error(framing_error),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Monitor: observes the DUT on the falling edge, only ever accumulates.
  int       cyc = 0;
  int       valid_hi_cnt = 0;
  int       valid_fall_cnt = 0;
  int       last_rise_cyc = 0;
  int       fe_cnt = 0;
  int       ov_cnt = 0;
  int       hs_n = 0;
  int       busy_run = 0;
  int       last_busy_run = 0;
  logic     valid_prev = 1'b0;
  logic [7:0] got_mem [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_if.rx_valid) valid_hi_cnt++;
    if (rx_if.rx_valid && !valid_prev) last_rise_cyc = cyc;
    if (!rx_if.rx_valid && valid_prev) valid_fall_cnt++;
    valid_prev = rx_if.rx_valid;
    if (framing_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rx_if.rx_valid && rx_if.rx_ready && hs_n < 64) begin
      got_mem[hs_n] = rx_if.rx_data;
      hs_n++;
    end
    if (busy) busy_run++;
    else begin
      if (busy_run != 0) last_busy_run = busy_run;
      busy_run = 0;
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Frame-level reference model of the holding register: a completed byte
  // is kept if the register is empty or being emptied, otherwise dropped.
  logic       mdl_full = 1'b0;
  logic [7:0] mdl_data = 8'h00;
  int         mdl_ovr  = 0;
  logic [7:0] exp_q [$];

  task automatic mdl_complete(input logic [7:0] b, input logic rdy);
    if (!mdl_full || rdy) begin
      if (mdl_full) exp_q.push_back(mdl_data);
      mdl_data = b;
      mdl_full = 1'b1;
    end else begin
      mdl_ovr++;
    end
  endtask

  task automatic mdl_drain();
    if (mdl_full) exp_q.push_back(mdl_data);
    mdl_full = 1'b0;
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int bitlen);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = fr[i];
      repeat (bitlen) @(posedge clk);
      #1;
    end
  endtask

  int s_valid, s_fe, s_ov, s_hs, s_fall, t0, d;
  logic [7:0] b;

  initial begin
    uart_rxd       = 1'b1;
    rx_if.rx_ready = 1'b0;
    reset          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_valid", rx_if.rx_valid, 0);
    check("reset_rx_data", rx_if.rx_data, 0);
    check("reset_framing_error", framing_error, 0);
    check("reset_overrun", overrun, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    idle(10);

    // Ideal frame 0x55, consumer always ready.
    rx_if.rx_ready = 1'b1;
    s_valid = valid_hi_cnt; s_hs = hs_n;
    t0 = cyc;
    send_frame(8'h55, 1'b1, DIV);
    idle(20);
    mdl_complete(8'h55, 1'b1); mdl_drain();
    check("ideal_valid_cycles", valid_hi_cnt - s_valid, 1);
    check("ideal_handshakes", hs_n - s_hs, 1);
    check("ideal_data", got_mem[s_hs], exp_q.pop_front());
    d = last_rise_cyc - t0;
    check("ideal_latency_window", (d >= HALF + 9*DIV) && (d <= HALF + 9*DIV + 5), 1);
    check("ideal_busy_after", busy, 0);

    // 30-cycle low glitch on the idle line.
    s_valid = valid_hi_cnt; s_fe = fe_cnt;
    uart_rxd = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    idle(100);
    check("glitch_no_valid", valid_hi_cnt - s_valid, 0);
    check("glitch_no_fe", fe_cnt - s_fe, 0);
    check("glitch_busy_len", (last_busy_run > 0) && (last_busy_run <= 52), 1);
    check("glitch_busy_after", busy, 0);

    // Bad stop bit, line held low, then a good frame.
    s_valid = valid_hi_cnt; s_fe = fe_cnt; s_hs = hs_n;
    send_frame(8'hA3, 1'b0, DIV);
    uart_rxd = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    idle(50);
    check("break_one_fe", fe_cnt - s_fe, 1);
    check("break_no_valid", valid_hi_cnt - s_valid, 0);
    send_frame(8'h3C, 1'b1, DIV);
    idle(20);
    mdl_complete(8'h3C, 1'b1); mdl_drain();
    check("after_break_hs", hs_n - s_hs, 1);
    check("after_break_data", got_mem[s_hs], exp_q.pop_front());

    // Back-to-back frames with the consumer stalled.
    rx_if.rx_ready = 1'b0;
    s_ov = ov_cnt; s_fe = fe_cnt; s_hs = hs_n;
    mdl_ovr = 0;
    send_frame(8'h01, 1'b1, DIV);
    send_frame(8'h02, 1'b1, DIV);
    idle(20);
    mdl_complete(8'h01, 1'b0);
    mdl_complete(8'h02, 1'b0);
    check("b2b_valid", rx_if.rx_valid, 1);
    check("b2b_data_held", rx_if.rx_data, mdl_data);
    check("b2b_overrun_pulses", ov_cnt - s_ov, mdl_ovr);
    check("b2b_no_fe", fe_cnt - s_fe, 0);
    rx_if.rx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rx_if.rx_ready = 1'b0;
    mdl_drain();
    check("b2b_valid_dropped", rx_if.rx_valid, 0);
    check("b2b_consumed", got_mem[s_hs], exp_q.pop_front());

    // Ready raised exactly in the completion cycle of 0x7E while 0x11 is held.
    send_frame(8'h11, 1'b1, DIV);
    idle(30);
    mdl_complete(8'h11, 1'b0);
    check("hold_0x11", rx_if.rx_data, mdl_data);
    s_ov = ov_cnt; s_hs = hs_n; s_fall = valid_fall_cnt;
    fork
      send_frame(8'h7E, 1'b1, DIV);
      begin
        repeat (HALF + 9*DIV + 2) @(posedge clk);
        #1;
        rx_if.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_if.rx_ready = 1'b0;
        mdl_complete(8'h7E, 1'b1);
        check("refill_data", rx_if.rx_data, mdl_data);
        check("refill_valid", rx_if.rx_valid, 1);
      end
    join
    idle(20);
    check("refill_no_overrun", ov_cnt - s_ov, 0);
    check("refill_valid_never_fell", valid_fall_cnt - s_fall, 0);
    check("refill_consumed_old", got_mem[s_hs], exp_q.pop_front());
    rx_if.rx_ready = 1'b1;
    idle(5);
    mdl_drain();
    check("refill_drain", got_mem[s_hs + 1], exp_q.pop_front());

    // Reset during data bit 4; remaining bits of that frame are high.
    s_valid = valid_hi_cnt; s_fe = fe_cnt; s_hs = hs_n;
    fork
      send_frame(8'hF0, 1'b1, DIV);
      begin
        repeat (DIV + 4*DIV + HALF) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midreset_valid", rx_if.rx_valid, 0);
        check("midreset_data", rx_if.rx_data, 0);
        check("midreset_fe", framing_error, 0);
        check("midreset_ov", overrun, 0);
        check("midreset_busy", busy, 0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
      end
    join
    idle(50);
    check("midreset_no_valid", valid_hi_cnt - s_valid, 0);
    check("midreset_no_fe", fe_cnt - s_fe, 0);
    send_frame(8'hF0, 1'b1, DIV);
    idle(20);
    mdl_complete(8'hF0, 1'b1); mdl_drain();
    check("after_reset_data", got_mem[s_hs], exp_q.pop_front());

    // +/-2% baud error.
    s_hs = hs_n;
    send_frame(8'h96, 1'b1, 98);
    idle(20);
    send_frame(8'h96, 1'b1, 102);
    idle(20);
    check("baud_fast", got_mem[s_hs], 8'h96);
    check("baud_slow", got_mem[s_hs + 1], 8'h96);

    // Randomised frames, gaps and small baud offsets, consumer always ready.
    s_hs = hs_n; s_fe = fe_cnt; s_ov = ov_cnt;
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, int'($urandom_range(98, 102)));
      mdl_complete(b, 1'b1); mdl_drain();
      idle(int'($urandom_range(0, 15)));
    end
    idle(20);
    check("rand_count", hs_n - s_hs, 8);
    for (int k = 0; k < 8; k++) begin
      if (exp_q.size() != 0) check($sformatf("rand_byte_%0d", k), got_mem[s_hs + k], exp_q.pop_front());
    end
    check("rand_no_fe", fe_cnt - s_fe, 0);
    check("rand_no_ov", ov_cnt - s_ov, 0);
    check("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
